// File: rtl/perdio_pkg.sv
// perdio_pkg: shared definitions for the life-loss monitor.
//   state_e  - monitor state encoding (PLAY / RESPAWN / GAMEOVER)
//   LIVES_W  - width of the lives register
//   HOLD_W   - width of the hit persistence counter
//   BLANK_W  - width of the respawn blanking counter
package perdio_pkg;

    typedef enum logic [1:0] {
        ST_PLAY     = 2'd0,
        ST_RESPAWN  = 2'd1,
        ST_GAMEOVER = 2'd2
    } state_e;

    localparam int LIVES_W = 4;
    localparam int HOLD_W  = 4;
    localparam int BLANK_W = 8;

endpackage

// File: rtl/perdio_or_reduce.sv
// perdio_or_reduce: masks the per-channel hit flags and OR-reduces them.
//   hit_i    [N_CH] - raw collision flags
//   mask_i   [N_CH] - channel enables (0 = channel ignored)
//   masked_o [N_CH] - hit_i AND mask_i
//   any_o           - OR of masked_o
// Purely combinational.
module perdio_or_reduce #(
    parameter int N_CH = 8
) (
    input  logic [N_CH-1:0] hit_i,
    input  logic [N_CH-1:0] mask_i,
    output logic [N_CH-1:0] masked_o,
    output logic            any_o
);

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_mask
            assign masked_o[gi] = hit_i[gi] & mask_i[gi];
        end
    endgenerate

    assign any_o = |masked_o;

endmodule

// File: rtl/perdio_monitor.sv
// perdio_monitor: counts lives in a frogger-style game.
// A loss is taken when any enabled hit channel stays asserted for HOLD_CYCLES
// consecutive enabled cycles while playing. After a non-final loss the monitor
// blanks hits for RESPAWN_CYCLES enabled cycles; the final loss parks it in
// GAMEOVER until restart or reset.
//   PERDIO_MONITOR_CLOCK_50      - system clock
//   PERDIO_MONITOR_RESET_InHigh  - synchronous active-high reset
//   PERDIO_MONITOR_hit_In        - per-channel collision flags
//   PERDIO_MONITOR_mask_In       - per-channel enable
//   PERDIO_MONITOR_enable_In     - game running (low freezes)
//   PERDIO_MONITOR_restart_In    - reload lives and return to PLAY
//   PERDIO_MONITOR_perdio_Out    - one-cycle pulse per life lost
//   PERDIO_MONITOR_gameover_Out  - high while in GAMEOVER
//   PERDIO_MONITOR_respawn_Out   - high while in RESPAWN
//   PERDIO_MONITOR_lives_Out     - remaining lives
//   PERDIO_MONITOR_cause_Out     - masked hits captured at the last loss
module perdio_monitor
    import perdio_pkg::*;
#(
    parameter int N_CH           = 8,
    parameter int LIVES          = 3,
    parameter int HOLD_CYCLES    = 2,
    parameter int RESPAWN_CYCLES = 16
) (
    input  logic                PERDIO_MONITOR_CLOCK_50,
    input  logic                PERDIO_MONITOR_RESET_InHigh,
    input  logic [N_CH-1:0]     PERDIO_MONITOR_hit_In,
    input  logic [N_CH-1:0]     PERDIO_MONITOR_mask_In,
    input  logic                PERDIO_MONITOR_enable_In,
    input  logic                PERDIO_MONITOR_restart_In,
    output logic                PERDIO_MONITOR_perdio_Out,
    output logic                PERDIO_MONITOR_gameover_Out,
    output logic                PERDIO_MONITOR_respawn_Out,
    output logic [LIVES_W-1:0]  PERDIO_MONITOR_lives_Out,
    output logic [N_CH-1:0]     PERDIO_MONITOR_cause_Out
);

    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'(RESPAWN_CYCLES - 1);

    logic                clk;
    logic                srst;
    logic [N_CH-1:0]     masked_hit;
    logic                any_hit;

    state_e              state_q,    state_d;
    logic [HOLD_W-1:0]   hold_q,     hold_d;
    logic [BLANK_W-1:0]  blank_q,    blank_d;
    logic [LIVES_W-1:0]  lives_q,    lives_d;
    logic [N_CH-1:0]     cause_q,    cause_d;
    logic                perdio_q,   perdio_d;
    logic                gameover_q, gameover_d;
    logic                respawn_q,  respawn_d;

    assign clk  = PERDIO_MONITOR_CLOCK_50;
    assign srst = PERDIO_MONITOR_RESET_InHigh;

    perdio_or_reduce #(
        .N_CH (N_CH)
    ) u_or_reduce (
        .hit_i    (PERDIO_MONITOR_hit_In),
        .mask_i   (PERDIO_MONITOR_mask_In),
        .masked_o (masked_hit),
        .any_o    (any_hit)
    );

    // State and datapath registers; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q    <= ST_PLAY;
            hold_q     <= '0;
            blank_q    <= '0;
            lives_q    <= LIVES_INIT;
            cause_q    <= '0;
            perdio_q   <= 1'b0;
            gameover_q <= 1'b0;
            respawn_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            blank_q    <= blank_d;
            lives_q    <= lives_d;
            cause_q    <= cause_d;
            perdio_q   <= perdio_d;
            gameover_q <= gameover_d;
            respawn_q  <= respawn_d;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        blank_d  = blank_q;
        lives_d  = lives_q;
        cause_d  = cause_q;
        perdio_d = 1'b0;

        if (PERDIO_MONITOR_restart_In) begin
            // Restart beats a loss arriving on the same edge.
            state_d = ST_PLAY;
            hold_d  = '0;
            blank_d = '0;
            lives_d = LIVES_INIT;
            cause_d = '0;
        end else begin
            unique case (state_q)
                ST_PLAY: begin
                    if (!PERDIO_MONITOR_enable_In) begin
                        hold_d = '0;
                    end else if (any_hit) begin
                        if (hold_q == HOLD_LAST) begin
                            hold_d   = '0;
                            blank_d  = '0;
                            perdio_d = 1'b1;
                            cause_d  = masked_hit;
                            lives_d  = (lives_q != '0) ? lives_q - LIVES_W'(1) : '0;
                            state_d  = (lives_q > LIVES_W'(1)) ? ST_RESPAWN : ST_GAMEOVER;
                        end else begin
                            hold_d = hold_q + HOLD_W'(1);
                        end
                    end else begin
                        hold_d = '0;
                    end
                end
                ST_RESPAWN: begin
                    // Hits are ignored, so the persistence count restarts
                    // from zero when play resumes.
                    hold_d = '0;
                    if (PERDIO_MONITOR_enable_In) begin
                        if (blank_q == BLANK_LAST) begin
                            blank_d = '0;
                            state_d = ST_PLAY;
                        end else begin
                            blank_d = blank_q + BLANK_W'(1);
                        end
                    end
                end
                ST_GAMEOVER: begin
                end
                default: begin
                    state_d = ST_PLAY;
                end
            endcase
        end
    end

    // Level outputs are decoded from the next state so they land in
    // registers alongside the state itself.
    always_comb begin
        gameover_d = (state_d == ST_GAMEOVER);
        respawn_d  = (state_d == ST_RESPAWN);
    end

    assign PERDIO_MONITOR_perdio_Out   = perdio_q;
    assign PERDIO_MONITOR_gameover_Out = gameover_q;
    assign PERDIO_MONITOR_respawn_Out  = respawn_q;
    assign PERDIO_MONITOR_lives_Out    = lives_q;
    assign PERDIO_MONITOR_cause_Out    = cause_q;

endmodule

// File: tb/tb_perdio_monitor.sv
module tb_perdio_monitor;

    localparam int N_CH  = 8;
    localparam int LIVES = 3;
    localparam int HOLD  = 2;
    localparam int RESP  = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            restart;
    logic            en;
    logic [N_CH-1:0] hit;
    logic [N_CH-1:0] mask;

    logic            perdio;
    logic            gameover;
    logic            respawn;
    logic [3:0]      lives;
    logic [N_CH-1:0] cause;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: life bookkeeping in terms of hit streak length and
    // remaining blanking cycles.
    int              m_lives;
    int              m_streak;
    int              m_resp_left;
    bit              m_over;
    bit              m_perdio;
    logic [N_CH-1:0] m_cause;

    always #5 clk = ~clk;

    perdio_monitor #(
        .N_CH           (N_CH),
        .LIVES          (LIVES),
        .HOLD_CYCLES    (HOLD),
        .RESPAWN_CYCLES (RESP)
    ) dut (
        .PERDIO_MONITOR_CLOCK_50     (clk),
        .PERDIO_MONITOR_RESET_InHigh (rst),
        .PERDIO_MONITOR_hit_In       (hit),
        .PERDIO_MONITOR_mask_In      (mask),
        .PERDIO_MONITOR_enable_In    (en),
        .PERDIO_MONITOR_restart_In   (restart),
        .PERDIO_MONITOR_perdio_Out   (perdio),
        .PERDIO_MONITOR_gameover_Out (gameover),
        .PERDIO_MONITOR_respawn_Out  (respawn),
        .PERDIO_MONITOR_lives_Out    (lives),
        .PERDIO_MONITOR_cause_Out    (cause)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_edge();
        logic [N_CH-1:0] mh;
        mh = hit & mask;
        if (rst || restart) begin
            m_lives     = LIVES;
            m_streak    = 0;
            m_resp_left = 0;
            m_over      = 1'b0;
            m_perdio    = 1'b0;
            m_cause     = '0;
        end else begin
            m_perdio = 1'b0;
            if (m_over) begin
                // absorbing
            end else if (!en) begin
                m_streak = 0;
            end else if (m_resp_left > 0) begin
                m_resp_left--;
            end else if (mh != '0) begin
                m_streak++;
                if (m_streak == HOLD) begin
                    m_streak = 0;
                    m_lives--;
                    m_perdio = 1'b1;
                    m_cause  = mh;
                    if (m_lives == 0) m_over = 1'b1;
                    else              m_resp_left = RESP;
                end
            end else begin
                m_streak = 0;
            end
        end
    endtask

    // One clock: advance DUT and model, then compare every output.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        model_edge();
        check("perdio",   32'(perdio),   32'(m_perdio));
        check("gameover", 32'(gameover), 32'(m_over));
        check("respawn",  32'(respawn),  32'(m_resp_left > 0));
        check("lives",    32'(lives),    32'(m_lives));
        check("cause",    32'(cause),    32'(m_cause));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst = 1'b1; restart = 1'b0; en = 1'b1; hit = '0; mask = 8'hFF;

        // Reset
        step();
        rst = 1'b0;
        check("rst_lives", 32'(lives), 32'd3);
        check("rst_cause", 32'(cause), 32'd0);
        check("rst_resp",  32'(respawn), 32'd0);
        $display("[TB] reset: lives=%0d", lives);

        // Single-cycle hit is not a loss
        hit = 8'h04; step();
        hit = '0;    step();
        check("030_lives",  32'(lives),  32'd3);
        check("030_perdio", 32'(perdio), 32'd0);
        $display("[TB] 1-cycle hit: lives=%0d", lives);

        // Two-cycle hit is a loss followed by 16 respawn cycles
        hit = 8'h04; step();
        check("031_early", 32'(perdio), 32'd0);
        step();
        check("031_perdio", 32'(perdio),  32'd1);
        check("031_lives",  32'(lives),   32'd2);
        check("031_cause",  32'(cause),   32'h04);
        check("031_resp",   32'(respawn), 32'd1);
        hit = '0;
        for (int i = 0; i < RESP - 1; i++) begin
            step();
            check("031_resp_hold", 32'(respawn), 32'd1);
            check("031_pulse_one", 32'(perdio),  32'd0);
        end
        step();
        check("031_resp_end", 32'(respawn), 32'd0);
        $display("[TB] 2-cycle hit: lives=%0d cause=%0h", lives, cause);

        // Masked channel never counts
        mask = 8'hFB; hit = 8'h04;
        idle(10);
        check("032_masked", 32'(lives), 32'd2);
        hit = 8'h01; step(); step();
        check("032_perdio", 32'(perdio), 32'd1);
        check("032_cause",  32'(cause),  32'h01);
        hit = '0; mask = 8'hFF;
        idle(RESP);
        $display("[TB] masked channel: lives=%0d cause=%0h", lives, cause);

        // Three losses to game over
        restart = 1'b1; step(); restart = 1'b0;
        check("033_restart", 32'(lives), 32'd3);
        for (int k = 0; k < 3; k++) begin
            hit = 8'($urandom_range(1, 255));
            step(); step();
            check("033_perdio", 32'(perdio), 32'd1);
            check("033_lives",  32'(lives),  32'(2 - k));
            hit = '0;
            if (k < 2) idle(RESP);
        end
        check("033_over", 32'(gameover), 32'd1);
        hit = 8'hFF; en = 1'b0; idle(3); en = 1'b1; idle(5);
        check("033_absorb", 32'(gameover), 32'd1);
        check("033_zero",   32'(lives),    32'd0);
        hit = '0;
        $display("[TB] game over: lives=%0d gameover=%0d", lives, gameover);

        // Restart on the same edge as a qualifying loss
        restart = 1'b1; step(); restart = 1'b0;
        hit = 8'h04; step();
        restart = 1'b1; step(); restart = 1'b0;
        check("034_lives",  32'(lives),    32'd3);
        check("034_perdio", 32'(perdio),   32'd0);
        check("034_play",   32'(respawn | gameover), 32'd0);
        hit = '0; step();
        $display("[TB] restart vs loss: lives=%0d", lives);

        // Reset during respawn
        hit = 8'h04; step(); step();
        hit = '0; idle(4);
        check("035_in_resp", 32'(respawn), 32'd1);
        rst = 1'b1; step(); rst = 1'b0;
        check("035_resp",  32'(respawn), 32'd0);
        check("035_lives", 32'(lives),   32'd3);
        check("035_cause", 32'(cause),   32'd0);
        $display("[TB] reset mid-respawn: lives=%0d", lives);

        // Randomized play
        for (int i = 0; i < 4000; i++) begin
            rst     = ($urandom_range(0, 599) == 0);
            restart = ($urandom_range(0, 149) == 0);
            en      = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 15) == 0)
                mask = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'($urandom);
            if ($urandom_range(0, 2) == 0)
                hit = ($urandom_range(0, 1) != 0) ? '0 : 8'($urandom);
            step();
            if (m_perdio)
                $display("[TB] random loss cyc=%0d cause=%0h lives=%0d", cyc, cause, lives);
        end
        rst = 1'b0; restart = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/perdio_monitor.md
PERDIO_MONITOR -- requirements
Module: perdio_monitor

Interface
REQ-001 Parameter N_CH, default 8, number of collision/hazard input channels (legal 1..32).
REQ-002 Parameter LIVES, default 3, lives loaded at reset/restart (legal 1..15).
REQ-003 Parameter HOLD_CYCLES, default 2, consecutive masked-hit samples required to count a loss (legal 1..15).
REQ-004 Parameter RESPAWN_CYCLES, default 16, blanking cycles after a non-final loss (legal 1..255).
REQ-005 PERDIO_MONITOR_CLOCK_50  in  1  single system clock, all logic rising-edge.
REQ-006 PERDIO_MONITOR_RESET_InHigh  in  1  reset, synchronous, active-high.
REQ-007 PERDIO_MONITOR_hit_In  in  N_CH  per-channel collision flags (frog/vehicle, frog/water, timeout...).
REQ-008 PERDIO_MONITOR_mask_In  in  N_CH  channel enable; bit 0 excludes that channel.
REQ-009 PERDIO_MONITOR_enable_In  in  1  game running; low = freeze.
REQ-010 PERDIO_MONITOR_restart_In  in  1  reload lives, return to PLAY.
REQ-011 PERDIO_MONITOR_perdio_Out  out  1  one-cycle pulse per life lost.
REQ-012 PERDIO_MONITOR_gameover_Out  out  1  level, high in GAMEOVER.
REQ-013 PERDIO_MONITOR_respawn_Out  out  1  level, high in RESPAWN.
REQ-014 PERDIO_MONITOR_lives_Out  out  4  remaining lives, unsigned.
REQ-015 PERDIO_MONITOR_cause_Out  out  N_CH  masked hit vector captured at the loss, held until next loss/restart.

Function
REQ-016 any_hit SHALL be the OR over N_CH bits of (hit_In AND mask_In), combinational, unregistered.
REQ-017 States SHALL be PLAY, RESPAWN, GAMEOVER; all outputs registered.
REQ-018 PLAY, enable_In=1: persistence counter SHALL increment on each edge with any_hit=1 and clear on any edge with any_hit=0.
REQ-019 A loss SHALL be taken at the edge where any_hit=1 and counter=HOLD_CYCLES-1 (HOLD_CYCLES=1: first hit edge).
REQ-020 At a loss edge: lives decrement by 1, perdio_Out high for exactly the following cycle, cause_Out loads masked hits, counter clears.
REQ-021 After a loss, next state SHALL be RESPAWN if new lives>0, else GAMEOVER; lives SHALL never underflow below 0.
REQ-022 RESPAWN: hits ignored; blank counter counts RESPAWN_CYCLES enabled cycles, then PLAY with persistence counter 0.
REQ-023 enable_In=0: state, lives, and both counters SHALL hold, except the persistence counter clears; no loss taken.
REQ-024 GAMEOVER: absorbing; hits and enable_In ignored; lives_Out=0.
REQ-025 restart_In=1 in any state SHALL at that edge load lives=LIVES, state=PLAY, counters=0, cause_Out=0, perdio_Out=0; it wins over a simultaneous loss.
REQ-026 Hits continuously high across RESPAWN->PLAY SHALL require a fresh HOLD_CYCLES count before the next loss.

Reset
REQ-027 On reset edge: state PLAY, lives_Out=LIVES, perdio_Out=0, gameover_Out=0, respawn_Out=0, cause_Out=0, counters 0; reset overrides restart_In and all other inputs, including mid-RESPAWN.

Structure
REQ-028 Package perdio_pkg SHALL hold the state encoding (PLAY=2'd0, RESPAWN=2'd1, GAMEOVER=2'd2) and counter widths (4-bit lives/hold, 8-bit blank).
REQ-029 The masked N_CH-wide OR reduction SHALL be a sub-module perdio_or_reduce (parameter N_CH, purely combinational).

Verification
REQ-030 Defaults, mask=8'hFF, enable=1, hit_In=8'h04 for 1 cycle -> no perdio_Out, lives_Out stays 3.
REQ-031 hit_In=8'h04 held 2 cycles -> perdio_Out pulses 1 cycle, lives_Out=2, cause_Out=8'h04, respawn_Out high 16 cycles, then PLAY.
REQ-032 mask_In=8'hFB, hit_In=8'h04 held 10 cycles -> no loss; hit_In=8'h01 held 2 cycles -> loss, cause_Out=8'h01.
REQ-033 Three qualifying losses separated by respawns -> lives 3->2->1->0, gameover_Out=1 after third; further hits no pulse.
REQ-034 restart_In asserted same edge as a qualifying loss -> lives_Out=3, perdio_Out=0, state PLAY.
REQ-035 Reset asserted mid-RESPAWN (cycle 5 of 16) -> next cycle respawn_Out=0, lives_Out=3, cause_Out=0.
